// File: rtl/st_width_narrower_32to8.sv
// Avalon-ST width narrower: holds one IN_SYMBOLS-wide beat and replays it one
// symbol per cycle, first symbol from the MSBs, trimming the tail by in_empty.
module st_width_narrower_32to8 #(
  parameter int SYMBOL_W   = 8,
  parameter int IN_SYMBOLS = 4,
  parameter int ERROR_W    = 6,
  parameter int EMPTY_W    = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  output logic                           in_ready,
  input  logic                           in_valid,
  input  logic [SYMBOL_W*IN_SYMBOLS-1:0] in_data,
  input  logic [ERROR_W-1:0]             in_error,
  input  logic                           in_startofpacket,
  input  logic                           in_endofpacket,
  input  logic [EMPTY_W-1:0]             in_empty,
  input  logic                           out_ready,
  output logic                           out_valid,
  output logic [SYMBOL_W-1:0]            out_data,
  output logic [ERROR_W-1:0]             out_error,
  output logic                           out_startofpacket,
  output logic                           out_endofpacket
);

  localparam logic [EMPTY_W-1:0] LAST = EMPTY_W'(IN_SYMBOLS - 1);

  logic                                 r_full;
  logic [EMPTY_W-1:0]                   r_idx;
  logic [IN_SYMBOLS-1:0][SYMBOL_W-1:0]  r_data;
  logic [ERROR_W-1:0]                   r_err;
  logic                                 r_sop;
  logic                                 r_eop;
  logic [EMPTY_W-1:0]                   r_empty;

  logic [EMPTY_W-1:0] w_last_idx;
  logic [EMPTY_W-1:0] w_sel;
  logic               w_at_last;
  logic               w_xfer;
  logic               w_drain;
  logic               w_load;

  assign w_last_idx = r_eop ? (LAST - r_empty) : LAST;
  assign w_at_last  = (r_idx == w_last_idx);
  assign w_xfer     = r_full & out_ready;
  assign w_drain    = w_xfer & w_at_last;
  assign in_ready   = ~r_full | w_drain;
  assign w_load     = in_valid & in_ready;
  // symbol 0 lives in the MSB slot of the packed beat
  assign w_sel      = LAST - r_idx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_full  <= 1'b0;
      r_idx   <= '0;
      r_data  <= '0;
      r_err   <= '0;
      r_sop   <= 1'b0;
      r_eop   <= 1'b0;
      r_empty <= '0;
    end else if (w_load) begin
      r_full  <= 1'b1;
      r_idx   <= '0;
      r_data  <= in_data;
      r_err   <= in_error;
      r_sop   <= in_startofpacket;
      r_eop   <= in_endofpacket;
      // empty only means something on the eop beat
      r_empty <= in_endofpacket ? in_empty : '0;
    end else if (w_drain) begin
      r_full <= 1'b0;
      r_idx  <= '0;
    end else if (w_xfer) begin
      r_idx <= r_idx + 1'b1;
    end
  end

  assign out_valid         = r_full;
  assign out_data          = r_data[w_sel];
  assign out_error         = r_err;
  assign out_startofpacket = r_full & r_sop & (r_idx == '0);
  assign out_endofpacket   = r_full & r_eop & w_at_last;

endmodule

// File: tb/tb_st_width_narrower_32to8.sv
// Bench for st_width_narrower_32to8: directed cases plus random packets
// checked against a queue of expected symbols built from accepted beats.
module tb_st_width_narrower_32to8;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_ready, in_valid;
  logic [31:0] in_data;
  logic [5:0]  in_error;
  logic        in_startofpacket, in_endofpacket;
  logic [1:0]  in_empty;
  logic        out_ready, out_valid;
  logic [7:0]  out_data;
  logic [5:0]  out_error;
  logic        out_startofpacket, out_endofpacket;

  st_width_narrower_32to8 dut (
    .clk(clk), .reset(reset),
    .in_ready(in_ready), .in_valid(in_valid), .in_data(in_data),
    .in_error(in_error), .in_startofpacket(in_startofpacket),
    .in_endofpacket(in_endofpacket), .in_empty(in_empty),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .out_error(out_error), .out_startofpacket(out_startofpacket),
    .out_endofpacket(out_endofpacket)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic [5:0] e;
    logic       s;
    logic       p;
  } sym_t;

  sym_t q[$];
  int   nerr = 0;
  int   nchk = 0;
  int   n_sop = 0;
  int   n_eop = 0;

  logic       stalled = 1'b0;
  logic [7:0] prev_d;
  logic [5:0] prev_e;
  logic       prev_s, prev_p;
  logic       last_acc;
  logic [7:0] obs_d;
  logic [5:0] obs_e;
  logic       obs_s, obs_p, obs_v, obs_rdy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive inputs after negedge, check settled outputs, advance model.
  task automatic step(input logic v, input logic [31:0] d, input logic [5:0] e,
                      input logic s, input logic p, input logic [1:0] m,
                      input logic ordy);
    logic exp_rdy, acc, xfer;
    int   n;
    sym_t t;
    @(negedge clk);
    in_valid = v; in_data = d; in_error = e;
    in_startofpacket = s; in_endofpacket = p; in_empty = m; out_ready = ordy;
    #1;
    if (stalled) begin
      chk("stall_data", out_data, prev_d);
      chk("stall_err",  out_error, prev_e);
      chk("stall_sop",  out_startofpacket, prev_s);
      chk("stall_eop",  out_endofpacket, prev_p);
    end
    exp_rdy = (q.size() == 0) || (q.size() == 1 && ordy);
    chk("out_valid", out_valid, q.size() != 0);
    chk("in_ready",  in_ready, exp_rdy);
    if (q.size() != 0) begin
      chk("out_data", out_data, q[0].d);
      chk("out_err",  out_error, q[0].e);
      chk("out_sop",  out_startofpacket, q[0].s);
      chk("out_eop",  out_endofpacket, q[0].p);
    end
    obs_v = out_valid; obs_d = out_data; obs_e = out_error;
    obs_s = out_startofpacket; obs_p = out_endofpacket; obs_rdy = in_ready;
    stalled = out_valid && !ordy;
    prev_d = out_data; prev_e = out_error;
    prev_s = out_startofpacket; prev_p = out_endofpacket;
    if (out_valid && ordy) begin
      if (out_startofpacket) n_sop++;
      if (out_endofpacket)   n_eop++;
    end
    acc  = v && exp_rdy;
    xfer = (q.size() != 0) && ordy;
    if (xfer) void'(q.pop_front());
    if (acc) begin
      n = p ? 4 - int'(m) : 4;
      for (int k = 0; k < n; k++) begin
        t.d = d[31-8*k -: 8];
        t.e = e;
        t.s = s && (k == 0);
        t.p = p && (k == n - 1);
        q.push_back(t);
      end
    end
    last_acc = acc;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b0, 32'h0, 6'h0, 1'b0, 1'b0, 2'd0, 1'b1);
  endtask

  task automatic expect_sym(input string tag, input logic [7:0] d,
                            input logic s, input logic p);
    chk({tag, "_v"}, obs_v, 1'b1);
    chk({tag, "_d"}, obs_d, d);
    chk({tag, "_s"}, obs_s, s);
    chk({tag, "_p"}, obs_p, p);
  endtask

  logic [31:0] cur_d;
  logic [5:0]  cur_e;
  logic        cur_s, cur_p;
  logic [1:0]  cur_m;
  logic        have_beat;
  int          beats_left, pkts, cyc;

  initial begin
    reset = 1'b1;
    in_valid = 1'b0; in_data = '0; in_error = '0; in_startofpacket = 1'b0;
    in_endofpacket = 1'b0; in_empty = '0; out_ready = 1'b0;
    #12;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_data",  out_data, 8'h0);
    chk("rst_err",   out_error, 6'h0);
    chk("rst_sop",   out_startofpacket, 1'b0);
    chk("rst_eop",   out_endofpacket, 1'b0);
    chk("rst_rdy",   in_ready, 1'b1);
    @(negedge clk); reset = 1'b0;

    // single sop+eop beat, full width
    step(1'b1, 32'hA1B2C3D4, 6'h0, 1'b1, 1'b1, 2'd0, 1'b1);
    chk("t1_acc", last_acc, 1'b1);
    idle(1); expect_sym("t1_a1", 8'hA1, 1'b1, 1'b0);
    idle(1); expect_sym("t1_b2", 8'hB2, 1'b0, 1'b0);
    idle(1); expect_sym("t1_c3", 8'hC3, 1'b0, 1'b0);
    idle(1); expect_sym("t1_d4", 8'hD4, 1'b0, 1'b1);
    idle(1); chk("t1_done", obs_v, 1'b0);

    // two-beat packet, second beat loaded back-to-back on the drain cycle
    step(1'b1, 32'h11223344, 6'h0, 1'b1, 1'b0, 2'd0, 1'b1);
    step(1'b1, 32'h5566AAAA, 6'h0, 1'b0, 1'b1, 2'd2, 1'b1);
    expect_sym("t2_11", 8'h11, 1'b1, 1'b0); chk("t2_rdy0", obs_rdy, 1'b0);
    step(1'b1, 32'h5566AAAA, 6'h0, 1'b0, 1'b1, 2'd2, 1'b1);
    expect_sym("t2_22", 8'h22, 1'b0, 1'b0);
    step(1'b1, 32'h5566AAAA, 6'h0, 1'b0, 1'b1, 2'd2, 1'b1);
    expect_sym("t2_33", 8'h33, 1'b0, 1'b0);
    step(1'b1, 32'h5566AAAA, 6'h0, 1'b0, 1'b1, 2'd2, 1'b1);
    expect_sym("t2_44", 8'h44, 1'b0, 1'b0); chk("t2_acc", last_acc, 1'b1);
    idle(1); expect_sym("t2_55", 8'h55, 1'b0, 1'b0);
    idle(1); expect_sym("t2_66", 8'h66, 1'b0, 1'b1);
    idle(1); chk("t2_done", obs_v, 1'b0);

    // eop with empty=3: one symbol carrying sop and eop
    step(1'b1, 32'h9ABCDEF0, 6'h2A, 1'b1, 1'b1, 2'd3, 1'b1);
    idle(1); expect_sym("t3_9a", 8'h9A, 1'b1, 1'b1);
    chk("t3_err", obs_e, 6'h2A); chk("t3_rdy", obs_rdy, 1'b1);
    idle(1); chk("t3_done", obs_v, 1'b0);

    // async reset after two of four symbols
    step(1'b1, 32'hCAFEBABE, 6'h11, 1'b1, 1'b1, 2'd0, 1'b1);
    idle(2);
    @(negedge clk); reset = 1'b1; in_valid = 1'b0; #1;
    chk("t4_valid", out_valid, 1'b0);
    chk("t4_data",  out_data, 8'h0);
    chk("t4_err",   out_error, 6'h0);
    chk("t4_eop",   out_endofpacket, 1'b0);
    q.delete(); stalled = 1'b0;
    @(negedge clk); reset = 1'b0;
    idle(1); chk("t4_idle", obs_v, 1'b0);
    step(1'b1, 32'h01020304, 6'h0, 1'b1, 1'b1, 2'd0, 1'b1);
    idle(1); expect_sym("t4_01", 8'h01, 1'b1, 1'b0);
    idle(4);

    // empty ignored without eop
    step(1'b1, 32'hF1F2F3F4, 6'h0, 1'b1, 1'b0, 2'd3, 1'b1);
    idle(1); expect_sym("t5_f1", 8'hF1, 1'b1, 1'b0);
    idle(1); expect_sym("t5_f2", 8'hF2, 1'b0, 1'b0);
    idle(1); expect_sym("t5_f3", 8'hF3, 1'b0, 1'b0);
    idle(1); expect_sym("t5_f4", 8'hF4, 1'b0, 1'b0);
    idle(1); chk("t5_done", obs_v, 1'b0);

    // random packets, out_ready toggling 1010...
    n_sop = 0; n_eop = 0; pkts = 0; cyc = 0;
    have_beat = 1'b0; beats_left = 0;
    while ((pkts < 1000 || have_beat) && cyc < 60000) begin
      if (!have_beat && pkts < 1000) begin
        if (beats_left == 0) begin
          beats_left = $urandom_range(1, 3);
          cur_s = 1'b1;
        end else cur_s = 1'b0;
        cur_p = (beats_left == 1);
        cur_d = $urandom;
        cur_e = 6'($urandom);
        cur_m = 2'($urandom);
        have_beat = 1'b1;
      end
      step(have_beat && ($urandom_range(0, 3) != 0), cur_d, cur_e, cur_s, cur_p,
           cur_m, (cyc % 2) == 0);
      if (last_acc) begin
        have_beat = 1'b0;
        beats_left--;
        if (beats_left == 0) pkts++;
      end
      cyc++;
    end
    chk("rnd_bound", cyc < 60000, 1'b1);
    cyc = 0;
    while (q.size() != 0 && cyc < 100) begin
      idle(1);
      cyc++;
    end
    chk("rnd_drained", q.size(), 0);
    chk("rnd_sop_cnt", n_sop, 1000);
    chk("rnd_eop_cnt", n_eop, 1000);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
